key_serial_loader: RTL and testbench
====================================

KEY_SERIAL_LOADER -- requirements
Module: key_serial_loader

Interface
REQ-001 Parameter KEY_W, default 8, width of the key delivered to the locked FSM.
REQ-002 Parameter TIMEOUT, default 255, idle cycles allowed between accepted serial beats before abort.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin a key load or reload; sampled per cycle.
REQ-006 ser_valid  input  1  serial key beat present.
REQ-007 ser_data  input  1  serial key or parity bit.
REQ-008 ser_ready  output  1  loader accepts a beat this cycle; a beat transfers when ser_valid and ser_ready are both 1.
REQ-009 key_out  output  KEY_W  assembled key to the locked FSM's keyinput bus.
REQ-010 key_valid  output  1  key_out holds a checked key.
REQ-011 dut_rst  output  1  holds the locked FSM in reset until a checked key is present.
REQ-012 err  output  1  last load failed (parity or timeout).

Function
REQ-013 FSM states SHALL be IDLE, LOAD, CHECK, ARMED and ERROR; all outputs SHALL be decoded from registered state and registers only.
REQ-014 IDLE: ser_ready=0, key_valid=0, dut_rst=1, err=0, key_out=0; start=1 -> LOAD, clearing the shift register, beat counter and timeout counter.
REQ-015 LOAD: ser_ready=1; each transfer SHALL increment the beat counter; beats 0..KEY_W-1 SHALL write key bit i = beat i (LSB first).
REQ-016 LOAD: beat KEY_W is the parity bit and SHALL be latched; that transfer SHALL move to CHECK.
REQ-017 LOAD: timeout counter SHALL clear on every transfer and increment on every other cycle; reaching TIMEOUT SHALL move to ERROR.
REQ-018 A transfer in the cycle where the timeout counter would reach TIMEOUT SHALL be accepted; the timeout SHALL NOT fire.
REQ-019 CHECK lasts exactly one cycle with ser_ready=0; XOR of all key bits XOR parity = 0 -> ARMED, otherwise -> ERROR (even parity).
REQ-020 ARMED: key_valid=1, key_out=assembled key, dut_rst=0, ser_ready=0; state is held until start.
REQ-021 ARMED with start=1 -> LOAD; key_valid=0, key_out=0, dut_rst=1 from the next cycle.
REQ-022 ERROR: err=1, dut_rst=1, key_valid=0, key_out=0; start=1 -> LOAD with err cleared.
REQ-023 key_out SHALL be 0 in every state other than ARMED, so no partial key reaches the locked FSM.
REQ-024 start in LOAD or CHECK SHALL be ignored; ser_valid outside LOAD SHALL be ignored and not consumed.
REQ-025 Latency: start sampled at edge n -> ser_ready=1 after edge n; KEY_W+1 back-to-back beats -> CHECK after the last-beat edge -> key_valid=1 one edge later.
REQ-026 The beat and timeout counters SHALL be wide enough for KEY_W and TIMEOUT with no wrap inside one load.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, with no clock edge: ser_ready=0, key_out=0, key_valid=0, dut_rst=1, err=0, and all counters and the shift register cleared.
REQ-028 rst asserted mid-load SHALL discard all received beats; the next load SHALL require a full KEY_W+1 beats.

Verification (KEY_W=8, TIMEOUT=255)
REQ-029 start, then beats 1,0,1,0,0,1,0,1 then parity 0, back-to-back -> CHECK one cycle, then key_out=0xA5, key_valid=1, dut_rst=0, err=0.
REQ-030 Same key bits with parity 1 -> err=1, key_out=0x00, key_valid=0, dut_rst=1; a following start clears err.
REQ-031 ser_valid low for 255 cycles after beat 3 -> ERROR; a repeat with a beat at cycle 254 -> load continues and arms 0xA5.
REQ-032 ARMED with 0xA5, pulse start, load 0x3C with parity 0 -> key_valid=0 and dut_rst=1 the cycle after start; key_out=0x3C when re-armed.
REQ-033 rst pulse after 4 beats -> outputs at IDLE values asynchronously; start plus 9 new beats of 0x3C -> key_out=0x3C.
REQ-034 start pulses during LOAD and ser_valid pulses in IDLE or ARMED -> no state change, no beat consumed, key unchanged.

Source files
------------

// File: rtl/key_serial_loader.sv
// Serial key loader: shifts a KEY_W-bit key plus an even-parity bit in LSB first,
// checks the parity and only then releases the locked FSM from reset with the key.
module key_serial_loader #(
  parameter int KEY_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             dut_rst,
  output logic             err
);

  localparam int BW = $clog2(KEY_W + 2);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, ERROR} state_t;

  state_t           state;
  logic [KEY_W-1:0] shreg;
  logic             par;
  logic [BW-1:0]    beat_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             xfer;
  logic             load_req;

  function automatic logic parity_ok(input logic [KEY_W-1:0] k, input logic p);
    return ~((^k) ^ p);
  endfunction

  assign xfer     = ser_valid && ser_ready;
  assign load_req = start && (state == IDLE || state == ARMED || state == ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      par       <= 1'b0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
      ser_ready <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      dut_rst   <= 1'b1;
      err       <= 1'b0;
    end else if (load_req) begin
      // (Re)load always starts from an empty key, whatever state we came from.
      state     <= LOAD;
      shreg     <= '0;
      par       <= 1'b0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
      ser_ready <= 1'b1;
      key_out   <= '0;
      key_valid <= 1'b0;
      dut_rst   <= 1'b1;
      err       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            tmo_cnt  <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BW'(KEY_W)) begin
              par       <= ser_data;
              state     <= CHECK;
              ser_ready <= 1'b0;
            end else begin
              // Right shift: after KEY_W beats, beat 0 lands in bit 0.
              shreg <= {ser_data, shreg[KEY_W-1:1]};
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state     <= ERROR;
            ser_ready <= 1'b0;
            err       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (parity_ok(shreg, par)) begin
            state     <= ARMED;
            key_out   <= shreg;
            key_valid <= 1'b1;
            dut_rst   <= 1'b0;
          end else begin
            state <= ERROR;
            err   <= 1'b1;
          end
        end
        IDLE, ARMED, ERROR: state <= state;
        default: begin
          state     <= IDLE;
          ser_ready <= 1'b0;
          key_out   <= '0;
          key_valid <= 1'b0;
          dut_rst   <= 1'b1;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_serial_loader.sv
// Directed bench for key_serial_loader (KEY_W=8, TIMEOUT=255); observes
// {ser_ready, key_valid, dut_rst, err, key_out} against hand-computed values.
module tb_key_serial_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ser_valid;
  logic       ser_data;
  logic       ser_ready;
  logic [7:0] key_out;
  logic       key_valid;
  logic       dut_rst;
  logic       err;

  int tests = 0;
  int fails = 0;

  key_serial_loader #(.KEY_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready), .key_out(key_out), .key_valid(key_valid),
    .dut_rst(dut_rst), .err(err)
  );

  always #5 clk = ~clk;

  // {ser_ready, key_valid, dut_rst, err, key_out}
  function automatic logic [11:0] obs();
    return {ser_ready, key_valid, dut_rst, err, key_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic b);
    ser_valid = 1'b1;
    ser_data  = b;
    tick();
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  task automatic load_key(input logic [7:0] k, input logic p);
    for (int i = 0; i < 8; i++) beat(k[i]);
    beat(p);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    #3;
    tests++;
    if (obs() !== {4'b0010, 8'h00}) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", obs(), {4'b0010, 8'h00});
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++;
    if (obs() !== {4'b0010, 8'h00}) begin
      fails++; $display("FAIL idle_hold got=%h exp=%h", obs(), {4'b0010, 8'h00});
    end
  endtask

  task automatic test_load_good();
    do_start();
    tests++;
    if (obs() !== {4'b1010, 8'h00}) begin
      fails++; $display("FAIL load_entry got=%h exp=%h", obs(), {4'b1010, 8'h00});
    end
    load_key(8'hA5, 1'b0);
    tests++;
    if (obs() !== {4'b0010, 8'h00}) begin
      fails++; $display("FAIL check_cycle got=%h exp=%h", obs(), {4'b0010, 8'h00});
    end
    tick();
    tests++;
    if (obs() !== {4'b0100, 8'hA5}) begin
      fails++; $display("FAIL armed_a5 got=%h exp=%h", obs(), {4'b0100, 8'hA5});
    end
  endtask

  task automatic test_parity_err();
    do_start();
    load_key(8'hA5, 1'b1);
    tick();
    tests++;
    if (obs() !== {4'b0011, 8'h00}) begin
      fails++; $display("FAIL parity_err got=%h exp=%h", obs(), {4'b0011, 8'h00});
    end
    do_start();
    tests++;
    if (obs() !== {4'b1010, 8'h00}) begin
      fails++; $display("FAIL err_clear got=%h exp=%h", obs(), {4'b1010, 8'h00});
    end
    // Odd-weight key with parity 1 is valid even parity.
    load_key(8'h01, 1'b1);
    tick();
    tests++;
    if (obs() !== {4'b0100, 8'h01}) begin
      fails++; $display("FAIL odd_key_ok got=%h exp=%h", obs(), {4'b0100, 8'h01});
    end
  endtask

  task automatic test_timeout();
    do_start();
    beat(1'b1); beat(1'b0); beat(1'b1);
    for (int i = 0; i < 254; i++) tick();
    tests++;
    if (obs() !== {4'b1010, 8'h00}) begin
      fails++; $display("FAIL tmo_254_alive got=%h exp=%h", obs(), {4'b1010, 8'h00});
    end
    tick();
    tests++;
    if (obs() !== {4'b0011, 8'h00}) begin
      fails++; $display("FAIL tmo_255_err got=%h exp=%h", obs(), {4'b0011, 8'h00});
    end
    do_start();
    beat(1'b1); beat(1'b0); beat(1'b1);
    for (int i = 0; i < 254; i++) tick();
    beat(1'b0); beat(1'b0); beat(1'b1); beat(1'b0); beat(1'b1);
    beat(1'b0);
    tick();
    tests++;
    if (obs() !== {4'b0100, 8'hA5}) begin
      fails++; $display("FAIL tmo_edge_beat got=%h exp=%h", obs(), {4'b0100, 8'hA5});
    end
  endtask

  task automatic test_reload();
    do_start();
    tests++;
    if (obs() !== {4'b1010, 8'h00}) begin
      fails++; $display("FAIL reload_drop got=%h exp=%h", obs(), {4'b1010, 8'h00});
    end
    load_key(8'h3C, 1'b0);
    tick();
    tests++;
    if (obs() !== {4'b0100, 8'h3C}) begin
      fails++; $display("FAIL reload_3c got=%h exp=%h", obs(), {4'b0100, 8'h3C});
    end
  endtask

  task automatic test_async_reset();
    do_start();
    beat(1'b1); beat(1'b1); beat(1'b1); beat(1'b1);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (obs() !== {4'b0010, 8'h00}) begin
      fails++; $display("FAIL async_rst got=%h exp=%h", obs(), {4'b0010, 8'h00});
    end
    #1;
    rst = 1'b0;
    // Beats offered in IDLE must be ignored.
    beat(1'b1); beat(1'b1);
    tests++;
    if (obs() !== {4'b0010, 8'h00}) begin
      fails++; $display("FAIL idle_ser_valid got=%h exp=%h", obs(), {4'b0010, 8'h00});
    end
    do_start();
    load_key(8'h3C, 1'b0);
    tick();
    tests++;
    if (obs() !== {4'b0100, 8'h3C}) begin
      fails++; $display("FAIL post_rst_3c got=%h exp=%h", obs(), {4'b0100, 8'h3C});
    end
  endtask

  task automatic test_ignore();
    beat(1'b1); beat(1'b0); beat(1'b1);
    tests++;
    if (obs() !== {4'b0100, 8'h3C}) begin
      fails++; $display("FAIL armed_ser_valid got=%h exp=%h", obs(), {4'b0100, 8'h3C});
    end
    do_start();
    // 0x5A LSB first: 0,1,0,1,1,0,1,0; start raised alongside beats and in gaps.
    beat(1'b0); beat(1'b1);
    start = 1'b1; beat(1'b0); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    beat(1'b1); beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b0);
    start = 1'b1; beat(1'b0); start = 1'b0;
    tests++;
    if (obs() !== {4'b0010, 8'h00}) begin
      fails++; $display("FAIL start_in_load got=%h exp=%h", obs(), {4'b0010, 8'h00});
    end
    start = 1'b1; tick(); start = 1'b0;
    tests++;
    if (obs() !== {4'b0100, 8'h5A}) begin
      fails++; $display("FAIL start_in_check got=%h exp=%h", obs(), {4'b0100, 8'h5A});
    end
  endtask

  initial begin
    test_reset();
    test_load_good();
    test_parity_err();
    test_timeout();
    test_reload();
    test_async_reset();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
